uart_prog_loader: RTL and testbench

Boot-time program loader between the UART receiver and the instruction memory of cpu_uart_top. It waits for a start byte, then assembles little-endian 32-bit words from the UART byte stream and writes them into consecutive instruction-memory cells. It verifies an XOR checksum and holds the CPU in reset until the image is accepted. The fetch stage reads only what this block has written; the CPU runs only after done=1.

---
 rtl/uart_prog_loader.sv | 158 +++++++++++++++
 tb/tb_uart_prog_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// Boot-time program loader sitting between the UART receiver and the
// instruction memory. After a start byte it assembles little-endian 32-bit
// words from the byte stream and writes them to consecutive word addresses.
// A trailing XOR checksum byte decides whether the CPU may leave reset.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx_valid  - one-cycle strobe, rx_data holds a received byte
//   rx_data   - received byte
//   mem_we    - one-cycle instruction-memory write strobe
//   mem_addr  - word address of the write (held until the next write)
//   mem_wdata - word to write (held until the next write)
//   cpu_hold  - 1 keeps the CPU core in reset
//   done      - image loaded and checksum good
//   err       - last image failed (bad checksum or timeout)
module uart_prog_loader #(
    parameter int          MEM_WORDS      = 64,
    parameter int          ADDR_W         = 8,
    parameter logic [7:0]  START_BYTE     = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(MEM_WORDS - 1);
    localparam logic [31:0]       TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    // Running XOR checksum over the image data bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        csum_next = acc ^ b;
    endfunction

    logic [2:0]        state_r;
    logic [1:0]        byte_idx_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [7:0]        checksum_r;
    logic [23:0]       shift_r;      // bytes 0..2 of the word being assembled
    logic [31:0]       idle_cnt_r;
    logic              timeout_hit_s;
    logic              is_start_s;

    // Timeout fires on the idle cycle that would bring the counter to the limit.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit_s = !rx_valid && ((idle_cnt_r + 32'd1) == TIMEOUT_LIM);
        end else begin
            timeout_hit_s = 1'b0;
        end
        is_start_s = rx_valid && (rx_data == START_BYTE);
    end

    // Loader state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            byte_idx_r <= 2'd0;
            word_idx_r <= '0;
            checksum_r <= 8'd0;
            shift_r    <= 24'd0;
            idle_cnt_r <= 32'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    // Both IDLE and ERROR (re)open an image on the start byte.
                    if (is_start_s) begin
                        state_r    <= ST_LOAD;
                        byte_idx_r <= 2'd0;
                        word_idx_r <= '0;
                        checksum_r <= 8'd0;
                        idle_cnt_r <= 32'd0;
                        err        <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        idle_cnt_r <= 32'd0;
                        checksum_r <= csum_next(checksum_r, rx_data);
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= word_idx_r;
                            mem_wdata  <= {rx_data, shift_r};
                            word_idx_r <= word_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            if (word_idx_r == LAST_WORD) begin
                                state_r <= ST_CHECK;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end else begin
                            // Little-endian: newest byte enters at the top.
                            shift_r <= {rx_data, shift_r[23:8]};
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERROR;
                        err     <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 32'd1;
                    end
                end
                ST_CHECK: begin
                    if (rx_valid) begin
                        idle_cnt_r <= 32'd0;
                        if (rx_data == checksum_r) begin
                            state_r  <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_r <= ST_ERROR;
                            err     <= 1'b1;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERROR;
                        err     <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    // Terminal until reset; every byte is ignored.
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader (MEM_WORDS=4, TIMEOUT_CYCLES=10).
// Expected memory writes are queued when the bytes are driven and compared
// by a monitor whenever mem_we is seen.
module tb_uart_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    uart_prog_loader #(
        .MEM_WORDS      (4),
        .ADDR_W         (8),
        .START_BYTE     (8'hA5),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [7:0]  img [16] = '{8'h93, 8'h80, 8'h80, 8'h00,
                              8'h13, 8'h01, 8'h80, 8'h00,
                              8'h63, 8'hC4, 8'h20, 8'h00,
                              8'h6F, 8'h00, 8'h00, 8'h00};
    logic [31:0] exp_words [4] = '{32'h00808093, 32'h00800113,
                                   32'h0020C463, 32'h0000006F};
    logic [39:0] exp_q [$];   // {addr, data}
    int tests_run  = 0;
    int fail_count = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_we", {63'd0, mem_we}, 64'd0);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check_value("wr_addr", {56'd0, mem_addr}, {56'd0, e[39:32]});
                check_value("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    // Drivers assume they are entered at a falling edge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_status(input string pfx, input logic hold, input logic dn, input logic er);
        check_value({pfx, "_hold"}, {63'd0, cpu_hold}, {63'd0, hold});
        check_value({pfx, "_done"}, {63'd0, done}, {63'd0, dn});
        check_value({pfx, "_err"},  {63'd0, err},  {63'd0, er});
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_value({pfx, "_we"},    {63'd0, mem_we},    64'd0);
        check_value({pfx, "_addr"},  {56'd0, mem_addr},  64'd0);
        check_value({pfx, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        check_status(pfx, 1'b1, 1'b0, 1'b0);
    endtask

    // Full image: start byte, 16 data bytes, checksum XORed with flip.
    task automatic send_image(input string pfx, input logic [7:0] flip);
        logic [7:0] cs;
        cs = 8'd0;
        send(8'hA5);
        check_value({pfx, "_err_after_start"}, {63'd0, err}, 64'd0);
        rx_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            cs = cs ^ img[i];
            if ((i % 4) == 3) exp_q.push_back({8'(i / 4), exp_words[i / 4]});
            send(img[i]);
        end
        check_value({pfx, "_done_before_cs"}, {63'd0, done}, 64'd0);
        send(cs ^ flip);
        rx_valid = 1'b0;
        check_value({pfx, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Noise before the start byte is ignored, then a good image loads.
        send(8'h00);
        send(8'h93);
        send(8'hFF);
        quiet(3);
        check_status("idle_noise", 1'b1, 1'b0, 1'b0);
        send_image("good1", 8'h00);
        check_status("good1", 1'b0, 1'b1, 1'b0);

        // DONE ignores everything, including the start byte.
        send(8'hA5);
        for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)));
        quiet(2);
        check_status("done_sticky", 1'b0, 1'b1, 1'b0);
        check_value("done_sticky_q", 64'(exp_q.size()), 64'd0);

        // Bad checksum, then recovery with a good image from ERROR.
        do_reset();
        send_image("bad", 8'h01);
        check_status("bad", 1'b1, 1'b0, 1'b1);
        send_image("retry", 8'h00);
        check_status("retry", 1'b0, 1'b1, 1'b0);

        // Timeout after a partial word; 0xA5 mid-image is plain data.
        do_reset();
        send(8'hA5);
        send(8'h93);
        send(8'h80);
        quiet(5);
        send(8'hA5);
        quiet(9);
        check_status("to_edge_minus1", 1'b1, 1'b0, 1'b0);
        quiet(1);
        check_status("timeout", 1'b1, 1'b0, 1'b1);
        send_image("after_to", 8'h00);
        check_status("after_to", 1'b0, 1'b1, 1'b0);

        // Reset after word 1 is written abandons the image.
        do_reset();
        send(8'hA5);
        for (int i = 0; i < 8; i++) begin
            if ((i % 4) == 3) exp_q.push_back({8'(i / 4), exp_words[i / 4]});
            send(img[i]);
        end
        quiet(1);
        check_value("midrst_q", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        send_image("reload", 8'h00);
        check_status("reload", 1'b0, 1'b1, 1'b0);

        quiet(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
